pio_out_pulse: RTL and testbench

//  Avalon-MM slave output PIO: write side of the PIO pair; drives a parallel out_port from software.

---
 rtl/pio_out_pulse_if.sv | 10 +
 rtl/pio_out_pulse.sv | 70 +++++++
 tb/tb_pio_out_pulse.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pio_out_pulse_if.sv
// pio_out_pulse_if: Avalon-MM slave bus of the output PIO
interface pio_out_pulse_if #(parameter int DATA_WIDTH = 10);
  logic [2:0] address;
  logic chipselect;
  logic write_n;
  logic [DATA_WIDTH-1:0] writedata;
  logic [DATA_WIDTH-1:0] readdata;
  modport master(output address, chipselect, write_n, writedata, input readdata);
  modport slave(input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pio_out_pulse.sv
// pio_out_pulse: Avalon-MM output PIO with set/clear strobes; pulse engine present when PIO_OUT_PULSE_EN is defined
module pio_out_pulse #(
  parameter int DATA_WIDTH = 10,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int PULSE_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  pio_out_pulse_if.slave bus,
  output logic [DATA_WIDTH-1:0] out_port
);
  logic wr;
  logic [DATA_WIDTH-1:0] data_reg, data_nxt, rd_nxt, pulse_mask;
  assign wr = bus.chipselect & ~bus.write_n;
  assign out_port = data_reg | pulse_mask;
  always_comb begin
    data_nxt = !wr ? data_reg :
               bus.address == 3'd0 ? bus.writedata :
               bus.address == 3'd4 ? data_reg | bus.writedata :
               bus.address == 3'd5 ? data_reg & ~bus.writedata : data_reg;
    rd_nxt = bus.address == 3'd0 ? data_reg :
             bus.address == 3'd2 ? pulse_mask : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg <= RESET_VALUE;
      bus.readdata <= '0;
    end else begin
      data_reg <= data_nxt;
      bus.readdata <= rd_nxt;
    end
  end
`ifdef PIO_OUT_PULSE_EN
  localparam int CW = $clog2(PULSE_CYCLES + 1);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [DATA_WIDTH-1:0] mask_nxt;
  logic fire;
  assign fire = wr && bus.address == 3'd2 && |bus.writedata;
  // a fresh write wins over expiry so retriggered bits never drop for a cycle
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    mask_nxt = pulse_mask;
    if (fire) begin
      state_nxt = ACTIVE;
      count_nxt = CW'(PULSE_CYCLES - 1);
      mask_nxt = pulse_mask | bus.writedata;
    end else if (state == ACTIVE) begin
      state_nxt = count == '0 ? IDLE : ACTIVE;
      count_nxt = count == '0 ? count : count - 1'b1;
      mask_nxt = count == '0 ? '0 : pulse_mask;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      pulse_mask <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      pulse_mask <= mask_nxt;
    end
  end
`else
  assign pulse_mask = '0;
`endif
endmodule

// File: tb/tb_pio_out_pulse.sv
// tb_pio_out_pulse: table-driven register checks plus pulse corner sequences
module tb_pio_out_pulse;
  localparam int DW = 10;
  localparam int PC = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [DW-1:0] out_port;
  int checks = 0;
  int failures = 0;
  logic [DW-1:0] rd_q[$];
  typedef struct {
    logic [2:0] addr;
    logic cs;
    logic wn;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;
    logic [DW-1:0] out;
  } vec_t;
  vec_t tbl[$];
  pio_out_pulse_if #(.DATA_WIDTH(DW)) bus();
  pio_out_pulse #(.DATA_WIDTH(DW), .RESET_VALUE(10'h000), .PULSE_CYCLES(PC)) dut (
    .clk(clk), .reset(reset), .bus(bus), .out_port(out_port));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  // rd is the value the read mux should capture on this edge; it is queued and checked when it appears
  task automatic step(input string name, input logic [2:0] a, input logic cs, input logic wn,
                      input logic [DW-1:0] wd, input logic [DW-1:0] rd, input logic [DW-1:0] out);
    bus.address = a;
    bus.chipselect = cs;
    bus.write_n = wn;
    bus.writedata = wd;
    rd_q.push_back(rd);
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    if (rd_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty", name);
    end else check({name, "/rd"}, bus.readdata, rd_q.pop_front());
    check({name, "/out"}, out_port, out);
  endtask
  initial begin
    bus.address = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    bus.writedata = '0;
    tbl = '{
      '{3'd0, 1'b1, 1'b0, 10'h2A5, 10'h000, 10'h2A5},
      '{3'd0, 1'b1, 1'b1, 10'h000, 10'h2A5, 10'h2A5},
      '{3'd4, 1'b1, 1'b0, 10'h00F, 10'h000, 10'h2AF},
      '{3'd0, 1'b1, 1'b1, 10'h000, 10'h2AF, 10'h2AF},
      '{3'd5, 1'b1, 1'b0, 10'h0A0, 10'h000, 10'h20F},
      '{3'd5, 1'b1, 1'b1, 10'h000, 10'h000, 10'h20F},
      '{3'd0, 1'b0, 1'b0, 10'h3FF, 10'h20F, 10'h20F},
      '{3'd0, 1'b1, 1'b1, 10'h3FF, 10'h20F, 10'h20F},
      '{3'd1, 1'b1, 1'b0, 10'h155, 10'h000, 10'h20F},
      '{3'd3, 1'b1, 1'b0, 10'h155, 10'h000, 10'h20F},
      '{3'd6, 1'b1, 1'b0, 10'h155, 10'h000, 10'h20F},
      '{3'd7, 1'b1, 1'b0, 10'h155, 10'h000, 10'h20F},
      '{3'd0, 1'b1, 1'b0, 10'h000, 10'h20F, 10'h000},
      '{3'd0, 1'b1, 1'b1, 10'h000, 10'h000, 10'h000}
    };
    repeat (2) @(negedge clk);
    check("reset/out", out_port, 10'h000);
    check("reset/rd", bus.readdata, 10'h000);
    reset = 1'b0;
    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("vec%0d", i), tbl[i].addr, tbl[i].cs, tbl[i].wn, tbl[i].wd, tbl[i].rd, tbl[i].out);
`ifdef PIO_OUT_PULSE_EN
    step("p_fire", 3'd2, 1'b1, 1'b0, 10'h001, 10'h000, 10'h001);
    for (int i = 1; i < PC; i++) step($sformatf("p_hold%0d", i), 3'd2, 1'b1, 1'b1, '0, 10'h001, 10'h001);
    step("p_expire", 3'd2, 1'b1, 1'b1, '0, 10'h001, 10'h000);
    step("p_idle", 3'd2, 1'b1, 1'b1, '0, 10'h000, 10'h000);
    step("p_zero", 3'd2, 1'b1, 1'b0, 10'h000, 10'h000, 10'h000);
    step("r_fire", 3'd2, 1'b1, 1'b0, 10'h001, 10'h000, 10'h001);
    for (int i = 1; i < PC; i++) step($sformatf("r_hold%0d", i), 3'd2, 1'b1, 1'b1, '0, 10'h001, 10'h001);
    step("r_retrig", 3'd2, 1'b1, 1'b0, 10'h002, 10'h001, 10'h003);
    for (int i = 1; i < PC; i++) step($sformatf("r_both%0d", i), 3'd2, 1'b1, 1'b1, '0, 10'h003, 10'h003);
    step("r_expire", 3'd2, 1'b1, 1'b1, '0, 10'h003, 10'h000);
    step("r_idle", 3'd2, 1'b1, 1'b1, '0, 10'h000, 10'h000);
    step("o_set", 3'd4, 1'b1, 1'b0, 10'h001, 10'h000, 10'h001);
    step("o_fire", 3'd2, 1'b1, 1'b0, 10'h003, 10'h000, 10'h003);
    step("o_clear", 3'd5, 1'b1, 1'b0, 10'h003, 10'h000, 10'h003);
    step("o_hold", 3'd2, 1'b1, 1'b1, '0, 10'h003, 10'h003);
    step("o_hold2", 3'd0, 1'b1, 1'b1, '0, 10'h000, 10'h003);
    step("o_expire", 3'd2, 1'b1, 1'b1, '0, 10'h003, 10'h000);
    step("a_fire", 3'd2, 1'b1, 1'b0, 10'h0F0, 10'h000, 10'h0F0);
    step("a_cyc2", 3'd2, 1'b1, 1'b1, '0, 10'h0F0, 10'h0F0);
    reset = 1'b1;
    @(negedge clk);
    check("a_reset/out", out_port, 10'h000);
    check("a_reset/rd", bus.readdata, 10'h000);
    reset = 1'b0;
    step("a_after", 3'd2, 1'b1, 1'b1, '0, 10'h000, 10'h000);
    step("a_after2", 3'd2, 1'b1, 1'b1, '0, 10'h000, 10'h000);
`else
    step("d_set", 3'd0, 1'b1, 1'b0, 10'h011, 10'h000, 10'h011);
    step("d_pulse", 3'd2, 1'b1, 1'b0, 10'h3FF, 10'h000, 10'h011);
    step("d_read2", 3'd2, 1'b1, 1'b1, '0, 10'h000, 10'h011);
    step("d_read0", 3'd0, 1'b1, 1'b1, '0, 10'h011, 10'h011);
    reset = 1'b1;
    @(negedge clk);
    check("d_reset/out", out_port, 10'h000);
    check("d_reset/rd", bus.readdata, 10'h000);
    reset = 1'b0;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
